// File: rtl/conv_encoder_k3.sv
// ---------------------------------------------------------------------------
// conv_encoder_k3
//
// Rate-1/2, constraint-length-3 convolutional encoder. One information word
// is accepted per frame and encoded MSB-first. Each encoding cycle emits one
// {g1,g2} symbol and also writes it into the assembled codeword. The first
// symbol lands in the codeword MSBs. No tail bits are appended.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous reset, active-low
//   i_start      start request; accepted only on a 0->1 transition while idle
//   i_data       information word, captured on accept
//   o_sym        current symbol {g1,g2}; holds its last value when not valid
//   o_sym_valid  o_sym carries a new symbol this cycle
//   o_code       assembled codeword, first symbol in the MSBs
//   o_busy       frame in progress (state ENC or DONE)
//   o_done       one-cycle pulse after the codeword is complete
//   o_dbg_state  current FSM state (IDLE=0, ENC=1, DONE=2)
//
// Handshake: the accept is edge-qualified. i_start is sampled every clock
// into a one-bit history flop. A frame begins only at an edge where the
// state is IDLE, i_start=1, and i_start was 0 at the previous edge. There
// is no backpressure on the symbol output: o_sym_valid marks each symbol
// for exactly one cycle.
// ---------------------------------------------------------------------------
module conv_encoder_k3 #(
  parameter int             SIZE_DATA_IN  = 8,
  parameter int             SIZE_DATA_OUT = 16,
  parameter int             SIZE_SYM      = 2,
  parameter logic [2:0]     G1            = 3'b111,
  parameter logic [2:0]     G2            = 3'b101
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic [SIZE_SYM-1:0]      o_sym,
  output logic                     o_sym_valid,
  output logic [SIZE_DATA_OUT-1:0] o_code,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [1:0]               o_dbg_state
);

  localparam int CW = $clog2(SIZE_DATA_IN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q,     state_d;
  logic [SIZE_DATA_IN-1:0]  data_q,      data_d;
  logic [1:0]               s_q,         s_d;
  logic [CW-1:0]            cnt_q,       cnt_d;
  logic                     start_prev_q, start_prev_d;
  logic [SIZE_SYM-1:0]      sym_q,       sym_d;
  logic                     sym_valid_q, sym_valid_d;
  logic [SIZE_DATA_OUT-1:0] code_q,      code_d;
  logic                     done_q,      done_d;

  logic                     accept;
  logic                     u;
  logic                     g1;
  logic                     g2;

  assign accept = (state_q == IDLE) && i_start && !start_prev_q;

  // The latched word is shifted left once per encoded bit, so the MSB is
  // always the current information bit.
  assign u  = data_q[SIZE_DATA_IN-1];
  assign g1 = ^(G1 & {u, s_q});
  assign g2 = ^(G2 & {u, s_q});

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    s_d          = s_q;
    cnt_d        = cnt_q;
    start_prev_d = i_start;
    sym_d        = sym_q;
    sym_valid_d  = 1'b0;
    code_d       = code_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = i_data;
          s_d     = 2'b00;
          cnt_d   = '0;
          code_d  = '0;
          state_d = ENC;
        end
      end
      ENC: begin
        sym_d       = {g1, g2};
        sym_valid_d = 1'b1;
        // Symbol k goes to code bits [SIZE_DATA_OUT-1-2k -: 2].
        for (int k = 0; k < SIZE_DATA_IN; k++) begin
          if (cnt_q == CW'(k)) begin
            code_d[SIZE_DATA_OUT-1-2*k -: SIZE_SYM] = {g1, g2};
          end
        end
        s_d    = {u, s_q[1]};
        data_d = {data_q[SIZE_DATA_IN-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(SIZE_DATA_IN - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      s_q          <= 2'b00;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      sym_q        <= '0;
      sym_valid_q  <= 1'b0;
      code_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      s_q          <= s_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_prev_d;
      sym_q        <= sym_d;
      sym_valid_q  <= sym_valid_d;
      code_q       <= code_d;
      done_q       <= done_d;
    end
  end

  assign o_sym       = sym_q;
  assign o_sym_valid = sym_valid_q;
  assign o_code      = code_q;
  assign o_busy      = (state_q != IDLE);
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_conv_encoder_k3.sv
// Bench for conv_encoder_k3: table-driven frames, symbol scoreboard, and
// hand-written sequences for start-hold, mid-frame data change, mid-frame
// reset and decoder loopback.
module tb_conv_encoder_k3;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_data;
  logic [1:0]  o_sym;
  logic        o_sym_valid;
  logic [15:0] o_code;
  logic        o_busy;
  logic        o_done;
  logic [1:0]  o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  logic [1:0] exp_q[$];

  conv_encoder_k3 dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_data      (i_data),
    .o_sym       (o_sym),
    .o_sym_valid (o_sym_valid),
    .o_code      (o_code),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: G1=111, G2=101, state starts at zero, MSB first.
  function automatic logic [15:0] model_encode(input logic [7:0] d);
    logic [15:0] c;
    logic s1, s0, u;
    c = '0; s1 = 1'b0; s0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      u = d[7-k];
      c[15-2*k -: 2] = {u ^ s1 ^ s0, u ^ s0};
      s0 = s1;
      s1 = u;
    end
    return c;
  endfunction

  // Error-free hard decision decoder: g2 = u ^ s0, so u = g2 ^ s0.
  function automatic logic [7:0] model_decode(input logic [15:0] c);
    logic [7:0] d;
    logic s1, s0, u;
    d = '0; s1 = 1'b0; s0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      u = c[15-2*k-1] ^ s0;
      d[7-k] = u;
      s0 = s1;
      s1 = u;
    end
    return d;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (o_sym_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sym_unexpected: got %b expected none", o_sym);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if (o_sym !== e) begin
          n_fail++;
          $display("FAIL sym: got %b expected %b", o_sym, e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Runs one frame. change_at>0 rewrites i_data to FF so that the new value
  // is present at edge E<change_at>. hold keeps i_start high afterwards.
  task automatic run_frame(input logic [7:0] d, input logic [15:0] exp_code,
                           input int change_at, input bit hold);
    int cyc;
    @(negedge i_clk);
    i_data  = d;
    i_start = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_code[15-2*k -: 2]);
    @(posedge i_clk);                       // E0
    cyc = 0;
    while (cyc < 20) begin
      @(negedge i_clk);
      if (cyc == 0) chk("busy_after_accept", {31'd0, o_busy}, 32'd1);
      if (!hold) i_start = 1'b0;
      if (change_at > 0 && cyc == change_at - 1) i_data = 8'hFF;
      if (o_done) break;
      cyc++;
    end
    if (cyc >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got none expected o_done within 20 cycles");
    end
    chk("done_latency", cyc, 32'd9);
    chk("code", {16'd0, o_code}, {16'd0, exp_code});
    chk("busy_at_done", {31'd0, o_busy}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    @(negedge i_clk);
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
    chk("code_hold", {16'd0, o_code}, {16'd0, exp_code});
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] code;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0;
    logic [7:0] w;
    logic [15:0] m;

    vecs[0] = '{8'hDA, 16'hD452};
    vecs[1] = '{8'hAA, 16'hE222};
    vecs[2] = '{8'h01, 16'h0003};
    vecs[3] = '{8'h33, 16'h0D7D};
    vecs[4] = '{8'h00, 16'h0000};
    vecs[5] = '{8'hFF, 16'hDAAA};

    i_rst_n = 1'b0; i_start = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge i_clk);
    chk("rst_sym",   {30'd0, o_sym}, 32'd0);
    chk("rst_valid", {31'd0, o_sym_valid}, 32'd0);
    chk("rst_code",  {16'd0, o_code}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy}, 32'd0);
    chk("rst_done",  {31'd0, o_done}, 32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // Table-driven frames
    foreach (vecs[i]) begin
      run_frame(vecs[i].data, vecs[i].code, 0, 1'b0);
      @(negedge i_clk);
    end

    // Start held high: exactly one frame
    d0 = done_cnt;
    run_frame(8'hDA, 16'hD452, 0, 1'b1);
    repeat (30) @(negedge i_clk);
    chk("hold_single_done", done_cnt - d0, 32'd1);
    chk("hold_code", {16'd0, o_code}, 32'h0000D452);
    chk("hold_busy", {31'd0, o_busy}, 32'd0);
    i_start = 1'b0;
    @(negedge i_clk);

    // i_data changed mid-frame has no effect
    run_frame(8'hDA, 16'hD452, 3, 1'b0);
    @(negedge i_clk);

    // Reset asserted at E4 of a frame
    d0 = done_cnt;
    i_data = 8'hDA; i_start = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(model_encode(8'hDA)[15-2*k -: 2]);
    @(posedge i_clk);                       // E0
    @(negedge i_clk); i_start = 1'b0;
    repeat (3) @(negedge i_clk);            // after E3
    i_rst_n = 1'b0;
    @(negedge i_clk);                       // after E4
    exp_q.delete();
    chk("mrst_sym",   {30'd0, o_sym}, 32'd0);
    chk("mrst_valid", {31'd0, o_sym_valid}, 32'd0);
    chk("mrst_code",  {16'd0, o_code}, 32'd0);
    chk("mrst_busy",  {31'd0, o_busy}, 32'd0);
    chk("mrst_done",  {31'd0, o_done}, 32'd0);
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk);
    chk("mrst_no_done", done_cnt - d0, 32'd0);
    run_frame(8'h33, 16'h0D7D, 0, 1'b0);
    @(negedge i_clk);

    // Loopback through the reference decoder
    for (int i = 0; i < 18; i++) begin
      if (i == 0)      w = 8'h00;
      else if (i == 1) w = 8'hFF;
      else             w = 8'($urandom_range(0, 255));
      m = model_encode(w);
      run_frame(w, m, 0, 1'b0);
      chk("loopback", {24'd0, model_decode(o_code)}, {24'd0, w});
      @(negedge i_clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

●
